lsp_cb_search: RTL and testbench

- Sequential nearest-neighbour search over one scalar LSP codebook. Lives in cbselect, directly consuming the 16-entry codebook ROM (e.g. cb1) for the Codec2 2400 encoder.
- For each target LSP value (Hz, Q15.16 two's complement), walks ROM addresses 0..M-1 and computes the squared error against each entry. Returns the index and error of the closest entry, which feed the LSP index packer.

---
 rtl/lsp_cb_search.sv | 119 +++++++++++
 tb/tb_lsp_cb_search.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsp_cb_search.sv
// Sequential nearest-neighbour search over a scalar LSP codebook.
// Walks ROM entries 0..M-1, tracks the minimum squared error and reports index/error.
module lsp_cb_search #(
   parameter int N  = 32,
   parameter int M  = 16,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [N-1:0]    target,
   output logic [AW-1:0]   rom_addr,
   input  logic [N-1:0]    rom_data,
   output logic            busy,
   output logic [AW-1:0]   best_index,
   output logic [2*N-1:0]  best_error,
   output logic            done
);

   localparam int EW = 2*N + 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEARCH,
      S_FINISH
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [N-1:0]       r_target;
   logic [EW-1:0]      r_best;
   logic [AW-1:0]      r_best_idx;
   logic [AW-1:0]      r_addr;
   logic               r_busy;
   logic               r_done;
   logic [AW-1:0]      r_best_index;
   logic [2*N-1:0]     r_best_error;

   logic signed [N:0]    w_diff;
   logic signed [EW-1:0] w_diff_ext;
   logic [EW-1:0]        w_err;
   logic                 w_last;
   logic                 w_better;
   logic [2*N-1:0]       w_best_sat;

   // One extra bit keeps the difference of two N-bit signed values exact.
   assign w_diff     = $signed({r_target[N-1], r_target}) - $signed({rom_data[N-1], rom_data});
   assign w_diff_ext = $signed({{(EW-N-1){w_diff[N]}}, w_diff});
   assign w_err      = $unsigned(w_diff_ext * w_diff_ext);
   assign w_last     = (r_addr == AW'(M-1));
   // Strict compare: equal errors keep the earlier (lower) index.
   assign w_better   = (w_err < r_best);
   assign w_best_sat = (|r_best[EW-1:2*N]) ? {(2*N){1'b1}} : r_best[2*N-1:0];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // NOTE: next state is defaulted first so no path through the case can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start)  w_next = S_SEARCH;
         S_SEARCH: if (w_last) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_target     <= '0;
         r_best       <= '1;
         r_best_idx   <= '0;
         r_addr       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_best_index <= '0;
         r_best_error <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_target   <= target;
                  r_addr     <= '0;
                  r_best     <= '1;
                  r_best_idx <= '0;
                  r_busy     <= 1'b1;
               end
            end
            S_SEARCH: begin
               if (w_better) begin
                  r_best     <= w_err;
                  r_best_idx <= r_addr;
               end
               if (!w_last) r_addr <= r_addr + 1'b1;
            end
            S_FINISH: begin
               r_best_index <= r_best_idx;
               r_best_error <= w_best_sat;
               r_done       <= 1'b1;
               r_busy       <= 1'b0;
               r_addr       <= '0;
            end
            default: r_addr <= '0;
         endcase
      end
   end

   assign rom_addr   = r_addr;
   assign busy       = r_busy;
   assign done       = r_done;
   assign best_index = r_best_index;
   assign best_error = r_best_error;

endmodule

// File: tb/tb_lsp_cb_search.sv
// Self-checking bench for lsp_cb_search: directed vectors, multi-cycle corner
// sequences and randomized codebooks against an exhaustive-search reference.
module tb_lsp_cb_search;

   localparam int N  = 32;
   localparam int M  = 16;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [N-1:0]    target;
   logic [AW-1:0]   rom_addr;
   logic [N-1:0]    rom_data;
   logic            busy;
   logic [AW-1:0]   best_index;
   logic [2*N-1:0]  best_error;
   logic            done;

   logic [N-1:0]    rom [M];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   lsp_cb_search #(.N(N), .M(M), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .target     (target),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .busy       (busy),
      .best_index (best_index),
      .best_error (best_error),
      .done       (done)
   );

   typedef struct {
      logic [N-1:0]   tgt;
      logic [AW-1:0]  idx;
      logic [2*N-1:0] err;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] hz(input int v);
      return N'(v * 65536);
   endfunction

   // Reference: exhaustive search with plain integer arithmetic, first minimum wins.
   function automatic void ref_search(input logic [N-1:0] t, output logic [AW-1:0] idx,
                                      output logic [2*N-1:0] err);
      longint d;
      logic [63:0] e;
      err = '1;
      idx = '0;
      for (int k = 0; k < M; k++) begin
         d = longint'($signed(t)) - longint'($signed(rom[k]));
         if (d < 0) d = -d;
         e = 64'(d) * 64'(d);
         if (e < err) begin
            err = e;
            idx = AW'(k);
         end
      end
   endfunction

   // Issues one search and waits (bounded) for done; lat counts edges after the start edge.
   task automatic do_search(input logic [N-1:0] t, output logic [AW-1:0] idx,
                            output logic [2*N-1:0] err, output int lat, output int busy_cnt);
      start  = 1'b1;
      target = t;
      step();
      start  = 1'b0;
      target = $urandom;
      lat      = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && lat < 40) begin
         step();
         lat++;
         if (busy) busy_cnt++;
      end
      idx = best_index;
      err = best_error;
   endtask

   initial begin
      vec_t           vecs [5];
      logic [AW-1:0]  gi, ri;
      logic [2*N-1:0] ge, re;
      int             lat, bc, lat2, n_done;

      for (int k = 0; k < M; k++) rom[k] = hz(500 + 50*k);

      vecs[0] = '{hz(500),  4'd0,  64'd0};
      vecs[1] = '{hz(1237), 4'd15, 64'd169 << 32};
      vecs[2] = '{hz(2000), 4'd15, 64'd562500 << 32};
      vecs[3] = '{hz(525),  4'd0,  64'd625 << 32};
      vecs[4] = '{hz(-100), 4'd0,  64'd360000 << 32};

      rst    = 1'b1;
      start  = 1'b0;
      target = '0;
      step();
      step();
      check("reset_busy",  64'(busy), 64'd0);
      check("reset_done",  64'(done), 64'd0);
      check("reset_index", 64'(best_index), 64'd0);
      check("reset_error", best_error, 64'd0);
      check("reset_addr",  64'(rom_addr), 64'd0);
      rst = 1'b0;
      step();

      for (int v = 0; v < 5; v++) begin
         do_search(vecs[v].tgt, gi, ge, lat, bc);
         check($sformatf("vec%0d_index", v), 64'(gi), 64'(vecs[v].idx));
         check($sformatf("vec%0d_error", v), ge, vecs[v].err);
         check($sformatf("vec%0d_latency", v), 64'(lat), 64'd17);
         check($sformatf("vec%0d_busy_cycles", v), 64'(bc), 64'd17);
         step();
         if (v == 0) check("done_one_cycle", 64'(done), 64'd0);
      end

      // Second start mid-search must be ignored.
      start  = 1'b1;
      target = hz(700);
      step();
      start = 1'b0;
      repeat (4) step();
      start  = 1'b1;
      target = hz(1100);
      step();
      start  = 1'b0;
      n_done = 0;
      gi = '0;
      ge = '1;
      for (int c = 0; c < 30; c++) begin
         if (done) begin
            n_done++;
            gi = best_index;
            ge = best_error;
         end
         step();
      end
      check("ignored_start_pulses", 64'(n_done), 64'd1);
      check("ignored_start_index", 64'(gi), 64'd4);
      check("ignored_start_error", ge, 64'd0);

      // Synchronous reset at E8 of a search.
      start  = 1'b1;
      target = hz(1500);
      step();
      start = 1'b0;
      repeat (7) step();
      rst = 1'b1;
      step();
      check("midrst_busy",  64'(busy), 64'd0);
      check("midrst_done",  64'(done), 64'd0);
      check("midrst_index", 64'(best_index), 64'd0);
      check("midrst_error", best_error, 64'd0);
      check("midrst_addr",  64'(rom_addr), 64'd0);
      rst = 1'b0;
      step();
      do_search(hz(1000), gi, ge, lat, bc);
      check("after_rst_index", 64'(gi), 64'd10);
      check("after_rst_error", ge, 64'd0);
      step();

      // Back-to-back searches: second start on the cycle after done.
      do_search(hz(830), gi, ge, lat, bc);
      check("b2b1_index", 64'(gi), 64'd7);
      check("b2b1_error", ge, 64'd400 << 32);
      do_search(hz(1180), gi, ge, lat2, bc);
      check("b2b2_index", 64'(gi), 64'd14);
      check("b2b2_error", ge, 64'd400 << 32);
      check("b2b_done_spacing", 64'(lat2 + 1), 64'd18);
      step();

      // Randomized codebooks, including full-range values and duplicated entries.
      for (int it = 0; it < 24; it++) begin
         for (int k = 0; k < M; k++) begin
            if (it % 3 == 0) rom[k] = $urandom;
            else             rom[k] = hz(int'($urandom_range(0, 4000)) - 500);
         end
         if (it % 4 == 1) rom[$urandom_range(8, 15)] = rom[$urandom_range(0, 7)];
         target = (it % 3 == 0) ? $urandom : hz(int'($urandom_range(0, 4000)) - 500);
         ref_search(target, ri, re);
         do_search(target, gi, ge, lat, bc);
         check($sformatf("rand%0d_index", it), 64'(gi), 64'(ri));
         check($sformatf("rand%0d_error", it), ge, re);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
